ex_muldiv_unit: RTL and testbench

//  Parametrised iterative multiply/divide unit for the EX stage: MULT, MULTU, DIV, DIVU.

---
 rtl/ex_muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage (MULT, MULTU, DIV, DIVU).
// Multiply is shift-add and divide is restoring. Each op takes WIDTH iterations
// plus one fix-up cycle, which applies signs and registers hi/lo.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; hi/lo hold the last result
// RUN   | one multiplier bit / one quotient bit per cycle
// FIX   | apply operand signs (or divide-by-zero values), write hi/lo
// DONE  | done pulse; hi/lo valid; pipeline released
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             annul,
    output logic             stall_req,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic                 is_div;
    logic                 div_zero;
    logic                 sign_a;
    logic                 sign_b;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH:0]       rem;
    logic [WIDTH-1:0]     quo;

    logic                 sign_a_in;
    logic                 sign_b_in;
    logic [WIDTH-1:0]     mag_a_in;
    logic [WIDTH-1:0]     mag_b_in;
    logic                 div_zero_in;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH+1:0]     div_shift;
    logic [WIDTH+1:0]     div_trial;
    logic                 div_ok;
    logic [WIDTH:0]       rem_next;
    logic [WIDTH-1:0]     quo_next;

    logic [2*WIDTH-1:0]   mul_res;
    logic [WIDTH-1:0]     hi_fix;
    logic [WIDTH-1:0]     lo_fix;

    // Operand magnitudes: signed ops work on |a|, |b| and fix the sign at the end.
    assign sign_a_in   = op[0] & src_a[WIDTH-1];
    assign sign_b_in   = op[0] & src_b[WIDTH-1];
    assign mag_a_in    = sign_a_in ? -src_a : src_a;
    assign mag_b_in    = sign_b_in ? -src_b : src_b;
    assign div_zero_in = op[1] & (src_b == '0);

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign stall_req = (start & (state == S_IDLE)) | (state == S_RUN) | (state == S_FIX);

    // One iteration step of both datapaths; only the one matching the op is committed.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
        acc_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {rem, quo[WIDTH-1]};
        div_trial = div_shift - {2'b00, mag_b};
        div_ok    = ~div_trial[WIDTH+1];
        rem_next  = div_ok ? div_trial[WIDTH:0] : div_shift[WIDTH:0];
        quo_next  = {quo[WIDTH-2:0], div_ok};
    end

    // Sign fix-up; divide by zero returns all-ones quotient and the original dividend.
    always_comb begin
        mul_res = (sign_a ^ sign_b) ? -acc : acc;
        hi_fix  = mul_res[2*WIDTH-1:WIDTH];
        lo_fix  = mul_res[WIDTH-1:0];
        if (div_zero) begin
            hi_fix = sign_a ? -mag_a : mag_a;
            lo_fix = '1;
        end else if (is_div) begin
            hi_fix = sign_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
            lo_fix = (sign_a ^ sign_b) ? -quo : quo;
        end
    end

    // Sequencer and datapath registers; annul drops everything back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            count    <= '0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            mag_a    <= '0;
            mag_b    <= '0;
            acc      <= '0;
            rem      <= '0;
            quo      <= '0;
            hi       <= '0;
            lo       <= '0;
        end else if (annul) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_div   <= op[1];
                        div_zero <= div_zero_in;
                        sign_a   <= sign_a_in;
                        sign_b   <= sign_b_in;
                        mag_a    <= mag_a_in;
                        mag_b    <= mag_b_in;
                        count    <= '0;
                        acc      <= {{WIDTH{1'b0}}, mag_b_in};
                        rem      <= '0;
                        quo      <= mag_a_in;
                        state    <= div_zero_in ? S_FIX : S_RUN;
                    end
                end
                S_RUN: begin
                    if (is_div) begin
                        rem <= rem_next;
                        quo <= quo_next;
                    end else begin
                        acc <= acc_next;
                    end
                    if (count == LAST) begin
                        state <= S_FIX;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_FIX: begin
                    hi    <= hi_fix;
                    lo    <= lo_fix;
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed cases plus random ops against an arithmetic model.
module tb_ex_muldiv_unit;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             annul;
    logic             stall_req;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] last_res;

    ex_muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .annul(annul), .stall_req(stall_req), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; returns {hi, lo}.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: p = {32'h0, a} * {32'h0, b};
            2'b01: p = 64'(sa * sb);
            2'b10: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit poke_run, input bit poke_done);
        logic [63:0] exp;
        int n;
        int exp_n;
        int bad;
        int extra;
        bit seen;
        exp   = ref_model(o, a, b);
        exp_n = (o[1] && b == 0) ? 1 : WIDTH + 1;
        n     = 0;
        bad   = 0;
        seen  = 0;
        @(negedge clk);
        op = o; src_a = a; src_b = b; start = 1'b1;
        #1;
        check({tag, ":stall_start"}, 64'(stall_req), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        op = 2'($urandom); src_a = $urandom; src_b = $urandom;
        while (!seen && n < 80) begin
            if (stall_req !== 1'b1 || busy !== 1'b1 || done !== 1'b0) bad++;
            if (poke_run && n == 4) start = 1'b1;
            if (poke_run && n == 5) start = 1'b0;
            @(posedge clk); #1;
            n++;
            if (done === 1'b1) seen = 1;
        end
        start = 1'b0;
        check({tag, ":latency"}, 64'(n), 64'(exp_n));
        check({tag, ":result"}, {hi, lo}, exp);
        check({tag, ":stall_busy_run"}, 64'(bad), 64'd0);
        check({tag, ":stall_done"}, {63'd0, stall_req}, 64'd0);
        if (poke_done) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ":pulse_end"}, {62'd0, done, busy}, 64'd0);
        last_res = exp;
        if (poke_run || poke_done) begin
            extra = 0;
            repeat (WIDTH + 4) begin
                @(posedge clk); #1;
                if (done !== 1'b0 || busy !== 1'b0) extra++;
            end
            check({tag, ":ignored_start"}, 64'(extra), 64'd0);
            check({tag, ":hold"}, {hi, lo}, last_res);
        end
    endtask

    initial begin
        int extra;
        logic [1:0] ro;
        rst = 1'b1; start = 1'b0; annul = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        last_res = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", {59'd0, done, busy, stall_req, 2'b00}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk); rst = 1'b0;

        run_op("mult_neg3x7", 2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        check("mult_neg3x7_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("div_neg7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        check("div_neg7_2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_7_2", 2'b10, 32'd7, 32'd2, 1'b0, 1'b0);
        check("divu_7_2_const", {hi, lo}, 64'h0000_0001_0000_0003);
        run_op("divu_by0", 2'b10, 32'd100, 32'd0, 1'b0, 1'b0);
        check("divu_by0_const", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
        run_op("div_by0", 2'b11, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);
        run_op("div_minneg1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("div_minneg1_const", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op("div_poke_run", 2'b11, 32'd12345, 32'hFFFF_FFF3, 1'b1, 1'b0);
        run_op("mult_poke_done", 2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);

        // Annul in flight at edge E+10, with a start in the same cycle.
        run_op("pre_annul", 2'b10, 32'd7, 32'd2, 1'b0, 1'b0);
        @(negedge clk);
        op = 2'b11; src_a = 32'hFFFF_0000; src_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        annul = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0; start = 1'b0;
        check("annul_idle", {62'd0, busy, done}, 64'd0);
        extra = 0;
        repeat (WIDTH + 4) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) extra++;
        end
        check("annul_no_done", 64'(extra), 64'd0);
        check("annul_hold", {hi, lo}, last_res);
        // Annul together with a start while idle: the start is dropped.
        @(negedge clk);
        op = 2'b00; src_a = 32'd5; src_b = 32'd5; start = 1'b1; annul = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0;
        check("annul_start_drop", {62'd0, busy, done}, 64'd0);
        run_op("post_annul", 2'b11, 32'hFFFF_0000, 32'd3, 1'b0, 1'b0);

        // Reset at edge E+5 of a MULT.
        @(negedge clk);
        op = 2'b01; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_reset", {hi, lo}, 64'd0);
        check("mid_reset_ctl", {61'd0, done, busy, stall_req}, 64'd0);

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom);
            run_op($sformatf("rnd%0d_op%0d", i, ro), ro, pick(), pick(), 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
